rob_retire: RTL
===============

Name: rob_retire

Overview:
- Reorder buffer for the R10000-style core; it is the consumer end of the free-list interface.
- Records the T_idx handed out by the free list at dispatch, and the T_old_idx read from the map table.
- Retires completed entries in order, handing T_old back to the free list (retire_en, retire_T_old_idx).
- On branch squash, supplies the free-list head checkpoint (FL_rollback_en, FL_rollback_idx).

Parameters:
- NUM_ROB, 8, ROB entries; power of two. ROB_W = $clog2(NUM_ROB).
- NUM_PR, 64, physical registers. PR_W = $clog2(NUM_PR).
- NUM_FL, 32, free-list entries. FL_W = $clog2(NUM_FL).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dispatch_en  in  1  allocate an entry at tail
- T_idx  in  PR_W  new physical register from the free list
- T_old_idx  in  PR_W  previous mapping from the map table
- FL_idx  in  FL_W  free-list head before this dispatch's allocation
- complete_en  in  1  mark an entry complete
- complete_rob_idx  in  ROB_W  entry to complete
- rollback_en  in  1  squash every entry younger than rollback_rob_idx
- rollback_rob_idx  in  ROB_W  surviving youngest entry (the mispredicted branch)
- ROB_valid  out  1  an entry can be accepted this cycle
- rob_idx  out  ROB_W  index dispatch_en will allocate (equals tail)
- retire_en  out  1  head entry retires at this edge
- retire_T_idx  out  PR_W  T of the retiring entry
- retire_T_old_idx  out  PR_W  T_old returned to the free list
- FL_rollback_en  out  1  free-list head must be restored
- FL_rollback_idx  out  FL_W  restored free-list head
- head  out  ROB_W  oldest entry pointer
- tail  out  ROB_W  next-allocate pointer
- count  out  ROB_W+1  valid entry count

Behaviour:
- Circular buffer. Per entry state: valid, complete, T, T_old, FL checkpoint.
- Reset (synchronous, active-high) clears:
  - head, tail and count to 0;
  - all valid and complete bits;
  - all outputs low, except ROB_valid = 1 and rob_idx = 0.
- ROB_valid = (count != NUM_ROB).
- Dispatch:
  - Accepted when dispatch_en && ROB_valid && !rollback_en.
  - The entry at tail is written with valid = 1, complete = 0, T, T_old and FL checkpoint.
  - tail <= tail + 1, wrapping mod NUM_ROB.
  - dispatch_en while full is ignored; no state changes.
- Complete:
  - Sets the complete bit at the next edge, only if that entry is valid; otherwise ignored.
  - Completing the head entry allows retirement one cycle later, never in the same cycle.
- Retire:
  - retire_en = valid[head] && complete[head]. It is combinational from registered state.
  - retire_T_idx and retire_T_old_idx come from the head entry.
  - On the edge: clear valid and complete at head; head <= head + 1, wrapping.
  - At most one retirement per cycle.
  - When retire_en = 0, the retire_* data outputs are 0.
- Rollback, with r = rollback_rob_idx and y = r + 1 mod NUM_ROB:
  - Legal only if valid[r]; when valid[r] = 0 the request is ignored and FL_rollback_en = 0.
  - If y == tail, no younger entries exist: FL_rollback_en = 0 and the pointers are unchanged.
  - Otherwise, combinationally: FL_rollback_en = 1 and FL_rollback_idx = FL checkpoint of entry y.
  - On the edge: clear valid and complete for every entry from y up to tail-1 (wrapping); tail <= y.
  - Rollback has priority over dispatch in the same cycle; that dispatch is dropped.
  - Retire in the same cycle still proceeds, since head is older than or equal to r.
- count is updated as count + dispatch_accepted − retire_en. On rollback, count = (y − head_next) mod NUM_ROB, where head_next is head after any same-cycle retire.
- Full boundary: when count == NUM_ROB, then head == tail; this is disambiguated by count, never by the pointers.
- Reset asserted mid-operation overrides dispatch, complete, retire and rollback in that cycle.

Optional Feature:
- Macro ROB_RETIRE_BYPASS_EN.
- Defined: ROB_valid = (count != NUM_ROB) || retire_en. When full with a retiring head, a dispatch is accepted into the slot freed at the same edge; count is unchanged.
- Undefined: ROB_valid = (count != NUM_ROB) only; a full ROB accepts no dispatch until a cycle after a retire.

Test Plan (NUM_ROB = 8):
1. Reset then idle: count = 0, head = tail = 0, ROB_valid = 1, retire_en = 0, FL_rollback_en = 0.
2. Fill and overflow:
   - Stimulus: 8 dispatches with T = 32..39, T_old = 0..7; then a 9th dispatch.
   - Required after 8: count = 8, ROB_valid = 0, tail = 0.
   - Required after the 9th: ignored, count stays 8.
3. Out-of-order complete, in-order retire:
   - Stimulus: complete entries 2, 1, then 0.
   - Required: retire_en is first seen one cycle after entry 0 completes, with retire_T_old_idx = 0; entries 1 and 2 retire on the next two cycles with T_old = 1, 2.
4. Rollback:
   - Stimulus: 5 entries with FL_idx = 10..14; rollback_rob_idx = 1.
   - Required same cycle: FL_rollback_en = 1, FL_rollback_idx = 12.
   - Required next cycle: tail = 2, count = 2.
   - A dispatch_en in the same cycle is dropped.
5. Rollback with no younger entry: rollback_rob_idx = tail − 1 -> FL_rollback_en = 0, no state change.
6. Full plus retiring head:
   - Without ROB_RETIRE_BYPASS_EN: ROB_valid = 0, dispatch dropped.
   - With the macro: ROB_valid = 1, dispatch accepted, count stays 8.

Source files
------------

// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - reorder buffer with in-order retire and free-list rollback checkpoints
//
// Purpose: circular reorder buffer sitting at the consumer end of the free list.
//   At dispatch it records the new physical register (T), the previous mapping (T_old)
//   and the free-list head checkpoint. Completed entries retire in order, returning
//   T_old to the free list. On a branch squash it supplies the free-list head checkpoint
//   of the oldest squashed entry.
//
// Optional feature macro: ROB_RETIRE_BYPASS_EN
//   When defined, a full ROB whose head is retiring this cycle still accepts a dispatch
//   into the slot freed at the same edge.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   dispatch_en         allocate an entry at tail (T_idx, T_old_idx, FL_idx recorded)
//   complete_en         mark entry complete_rob_idx complete (ignored if not valid)
//   rollback_en         squash every entry younger than rollback_rob_idx
//   ROB_valid, rob_idx  an entry can be accepted; index the next dispatch will use
//   retire_en           head entry retires at this edge, with retire_T_idx / retire_T_old_idx
//   FL_rollback_en      free-list head must be restored to FL_rollback_idx
//   head, tail, count   oldest pointer, next-allocate pointer, valid entry count

module rob_retire #(
  parameter int NUM_ROB = 8,
  parameter int NUM_PR  = 64,
  parameter int NUM_FL  = 32,
  parameter int ROB_W   = $clog2(NUM_ROB),
  parameter int PR_W    = $clog2(NUM_PR),
  parameter int FL_W    = $clog2(NUM_FL)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dispatch_en,
  input  logic [PR_W-1:0]    T_idx,
  input  logic [PR_W-1:0]    T_old_idx,
  input  logic [FL_W-1:0]    FL_idx,
  input  logic               complete_en,
  input  logic [ROB_W-1:0]   complete_rob_idx,
  input  logic               rollback_en,
  input  logic [ROB_W-1:0]   rollback_rob_idx,
  output logic               ROB_valid,
  output logic [ROB_W-1:0]   rob_idx,
  output logic               retire_en,
  output logic [PR_W-1:0]    retire_T_idx,
  output logic [PR_W-1:0]    retire_T_old_idx,
  output logic               FL_rollback_en,
  output logic [FL_W-1:0]    FL_rollback_idx,
  output logic [ROB_W-1:0]   head,
  output logic [ROB_W-1:0]   tail,
  output logic [ROB_W:0]     count
);

  localparam int CNT_W = ROB_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ROB);

  logic [NUM_ROB-1:0] valid;
  logic [NUM_ROB-1:0] complete;
  logic [PR_W-1:0]    t_mem     [NUM_ROB];
  logic [PR_W-1:0]    t_old_mem [NUM_ROB];
  logic [FL_W-1:0]    fl_mem    [NUM_ROB];

  logic               dispatch_acc;
  logic [ROB_W-1:0]   head_next;
  logic [ROB_W-1:0]   rb_young;   // oldest entry younger than the surviving branch
  logic               rb_active;
  logic [ROB_W-1:0]   rb_span;    // number of entries squashed
  logic [ROB_W-1:0]   rb_count;   // surviving entries after the squash edge
  logic [NUM_ROB-1:0] squash;

  assign retire_en        = valid[head] && complete[head];
  assign retire_T_idx     = retire_en ? t_mem[head]     : '0;
  assign retire_T_old_idx = retire_en ? t_old_mem[head] : '0;
  assign head_next        = head + ROB_W'(retire_en);

`ifdef ROB_RETIRE_BYPASS_EN
  assign ROB_valid = (count != FULL_CNT) || retire_en;
`else
  assign ROB_valid = (count != FULL_CNT);
`endif

  assign rob_idx      = tail;
  assign dispatch_acc = dispatch_en && ROB_valid && !rollback_en;

  // A rollback only does work when the branch entry is live and something younger exists.
  assign rb_young        = rollback_rob_idx + ROB_W'(1);
  assign rb_active       = rollback_en && valid[rollback_rob_idx] && (rb_young != tail);
  assign FL_rollback_en  = rb_active;
  assign FL_rollback_idx = rb_active ? fl_mem[rb_young] : '0;
  assign rb_span         = tail - rb_young;
  assign rb_count        = rb_young - head_next;

  // Entry i is squashed when its distance past rb_young (mod NUM_ROB) is below the span;
  // modular arithmetic handles wrap-around and the full case where head == tail.
  always_comb begin
    squash = '0;
    for (int i = 0; i < NUM_ROB; i++) begin
      squash[i] = rb_active && ((ROB_W'(i) - rb_young) < rb_span);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      complete <= '0;
    end else begin
      if (complete_en && valid[complete_rob_idx]) begin
        complete[complete_rob_idx] <= 1'b1;
      end

      if (retire_en) begin
        valid[head]    <= 1'b0;
        complete[head] <= 1'b0;
      end
      head <= head_next;

      if (rb_active) begin
        for (int i = 0; i < NUM_ROB; i++) begin
          if (squash[i]) begin
            valid[i]    <= 1'b0;
            complete[i] <= 1'b0;
          end
        end
        tail  <= rb_young;
        count <= {1'b0, rb_count};
      end else begin
        tail  <= tail + ROB_W'(dispatch_acc);
        count <= count + CNT_W'(dispatch_acc) - CNT_W'(retire_en);
      end

      // Placed last so a bypassed dispatch into the slot freed by retire wins.
      if (dispatch_acc) begin
        valid[tail]     <= 1'b1;
        complete[tail]  <= 1'b0;
        t_mem[tail]     <= T_idx;
        t_old_mem[tail] <= T_old_idx;
        fl_mem[tail]    <= FL_idx;
      end
    end
  end

endmodule
